// File: rtl/mmio_interconnect.sv
// Memory-mapped I/O interconnect: decodes master requests onto N peripheral slots via base/mask
// windows, waits for a per-slot ack with a timeout watchdog, and reports bus errors.
module mmio_interconnect #(
  parameter int unsigned                   N_SLOTS = 4,
  parameter int unsigned                   ADDR_W  = 64,
  parameter int unsigned                   DATA_W  = 64,
  parameter int unsigned                   ST_W    = 2,
  parameter logic [N_SLOTS*ADDR_W-1:0]     BASE    = '0,
  parameter logic [N_SLOTS*ADDR_W-1:0]     MASK    = '0,
  parameter int unsigned                   TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [ST_W-1:0]            m_store_type,
  input  logic                       m_valid,
  output logic                       m_ready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_err,
  output logic [N_SLOTS-1:0]         s_sel,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLOTS*DATA_W-1:0]  s_rdata,
  input  logic [N_SLOTS-1:0]         s_ack,
  output logic                       err_irq,
  output logic [7:0]                 err_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               miss_q;
  logic               hit;
  logic [N_SLOTS-1:0] hit_onehot;
  logic [DATA_W-1:0]  sel_rdata;
  logic               sel_ack;

  // Scan from the top so the lowest-index hitting window overwrites the rest.
  always_comb begin
    hit        = 1'b0;
    hit_onehot = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        hit           = 1'b1;
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (s_sel[i]) sel_rdata = s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign sel_ack = |(s_ack & s_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      miss_q    <= 1'b0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      s_sel     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      err_irq   <= 1'b0;
      err_count <= '0;
    end else begin
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      err_irq <= 1'b0;
      case (state_q)
        StIdle: begin
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_we    <= |m_store_type;
            cnt_q   <= '0;
            m_rdata <= '0;
            if (hit) begin
              s_sel   <= hit_onehot;
              state_q <= StWait;
            end else begin
              s_sel   <= '0;
              miss_q  <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StWait: begin
          if (sel_ack) begin
            m_rdata <= s_we ? '0 : sel_rdata;
            s_sel   <= '0;
            m_ready <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q == CntLast) begin
            s_sel   <= '0;
            m_rdata <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            err_irq <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          // A decode miss spends one extra RESP cycle so its latency matches a fast ack.
          if (miss_q) begin
            miss_q  <= 1'b0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            err_irq <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            m_rdata <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed scoreboard bench for mmio_interconnect: decode, ack latency, timeout, errors, reset.
module tb_mmio_interconnect;

  localparam int unsigned N = 4;
  // slot0 0x1xxx, slot1 0x2xxx, slot2 0x3xxx, slot3 0x2xxx-0x3xxx (overlaps 1 and 2)
  localparam logic [N*64-1:0] BASE_P = {64'h2000, 64'h3000, 64'h2000, 64'h1000};
  localparam logic [N*64-1:0] MASK_P = {64'hFFFF_FFFF_FFFF_E000, 64'hFFFF_FFFF_FFFF_F000,
                                        64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F000};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   m_addr = '0;
  logic [63:0]   m_wdata = '0;
  logic [1:0]    m_store_type = '0;
  logic          m_valid = 1'b0;
  logic          m_ready;
  logic [63:0]   m_rdata;
  logic          m_err;
  logic [N-1:0]  s_sel;
  logic          s_we;
  logic [63:0]   s_addr;
  logic [63:0]   s_wdata;
  logic [N*64-1:0] s_rdata = {64'hBBBB, 64'h5555, 64'hAAAA, 64'h1234};
  logic [N-1:0]  s_ack = '0;
  logic          err_irq;
  logic [7:0]    err_count;

  mmio_interconnect #(
    .N_SLOTS(N), .ADDR_W(64), .DATA_W(64), .ST_W(2),
    .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_store_type(m_store_type), .m_valid(m_valid), .m_ready(m_ready), .m_rdata(m_rdata),
    .m_err(m_err), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .err_irq(err_irq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total = 0;
  int exp_errs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ack_at = k acks on the k-th WAIT cycle (0 = never); noise is driven on every cycle.
  task automatic run_txn(input string tag, input logic [63:0] addr, input logic [1:0] st,
                         input logic [63:0] wdata, input logic [3:0] exp_sel, input int ack_at,
                         input logic [3:0] noise, input logic [63:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
    exp_t e;
    int   n;
    logic done;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    q.push_back(e);
    m_addr = addr;
    m_wdata = wdata;
    m_store_type = st;
    m_valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      s_ack = noise | ((ack_at != 0 && n == ack_at) ? exp_sel : 4'b0000);
      @(posedge clk);
      n++;
      #1;
      if (n == 1) check({tag, ":s_sel"}, s_sel, exp_sel);
      check({tag, ":s_wdata"}, s_wdata, wdata);
      check({tag, ":s_we"}, s_we, |st);
      if (m_ready) done = 1'b1;
    end
    s_ack = '0;
    e = q.pop_front();
    if (!done) check({tag, ":ready_seen"}, m_ready, 1);
    else begin
      check({tag, ":latency"}, n, e.lat);
      check({tag, ":m_rdata"}, m_rdata, e.rdata);
      check({tag, ":m_err"}, m_err, e.err);
      check({tag, ":err_irq"}, err_irq, e.err);
      check({tag, ":s_sel_resp"}, s_sel, 0);
    end
    if (e.err && exp_errs < 255) exp_errs++;
    check({tag, ":err_count"}, err_count, exp_errs);
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ":ready_pulse"}, m_ready, 0);
    check({tag, ":irq_pulse"}, err_irq, 0);
  endtask

  initial begin
    #2;
    check("rst:m_ready", m_ready, 0);
    check("rst:s_sel", s_sel, 0);
    check("rst:m_rdata", m_rdata, 0);
    check("rst:err_count", err_count, 0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    run_txn("rd0", 64'h1008, 2'b00, 64'h0, 4'b0001, 1, 4'b0000, 64'h1234, 1'b0, 2);
    run_txn("wr2", 64'h3040, 2'b11, 64'hDEAD, 4'b0100, 5, 4'b0000, 64'h0, 1'b0, 6);
    run_txn("miss", 64'h8000, 2'b00, 64'h77, 4'b0000, 0, 4'b0000, 64'h0, 1'b1, 2);
    run_txn("tmo", 64'h3000, 2'b00, 64'h0, 4'b0100, 0, 4'b0000, 64'h0, 1'b1, 17);

    // Late ack after the timeout must not produce a response.
    s_ack = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("late_ack:m_ready", m_ready, 0);
    end
    s_ack = '0;

    run_txn("ovl", 64'h2010, 2'b00, 64'h0, 4'b0010, 3, 4'b1000, 64'hAAAA, 1'b0, 4);

    // Reset in the middle of WAIT drops s_sel without a clock edge.
    m_addr = 64'h1000;
    m_store_type = 2'b00;
    m_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstw:s_sel_before", s_sel, 4'b0001);
    reset = 1'b1;
    #1;
    check("rstw:s_sel", s_sel, 0);
    check("rstw:err_count", err_count, 0);
    check("rstw:m_ready", m_ready, 0);
    exp_errs = 0;
    m_valid = 1'b0;
    #3 reset = 1'b0;

    run_txn("rd_after", 64'h1010, 2'b00, 64'h0, 4'b0001, 1, 4'b0000, 64'h1234, 1'b0, 2);

    for (int i = 0; i < 300; i++) begin
      run_txn("sat", 64'h9000, 2'b00, 64'h0, 4'b0000, 0, 4'b0000, 64'h0, 1'b1, 2);
    end
    check("sat:final", err_count, 8'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
